// File: rtl/cnn_frame_feeder_if.sv
// Handshake bundle between the frame feeder and its host / CNN pipeline.
// master: feeder side; slave: host + pipeline side.
interface cnn_frame_feeder_if #(
    parameter int AW         = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  go;
    logic                  pixel_ready;
    logic                  cnn_done;
    logic                  start;
    logic [DATA_WIDTH-1:0] pixel_out;
    logic                  pixel_in_valid;
    logic                  busy;
    logic                  frame_done;
    logic                  timeout_err;
    logic [AW:0]           pixel_count;

    modport master (
        input  wr_en, wr_addr, wr_data, go, pixel_ready, cnn_done,
        output start, pixel_out, pixel_in_valid, busy,
        output frame_done, timeout_err, pixel_count
    );

    modport slave (
        output wr_en, wr_addr, wr_data, go, pixel_ready, cnn_done,
        input  start, pixel_out, pixel_in_valid, busy,
        input  frame_done, timeout_err, pixel_count
    );
endinterface

// File: rtl/cnn_frame_feeder.sv
// Frame feeder: host-loaded frame buffer streamed in raster order to the CNN.
// Ports: clk, reset (async, active-low), bus (cnn_frame_feeder_if.master).
module cnn_frame_feeder #(
    parameter int IMG_WIDTH  = 4,
    parameter int IMG_HEIGHT = 4,
    parameter int DATA_WIDTH = 8,
    parameter int START_GAP  = 1,
    parameter int TIMEOUT    = 255
) (
    input logic clk,
    input logic reset,
    cnn_frame_feeder_if.master bus
);
    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int TMAX = (TIMEOUT > START_GAP) ? TIMEOUT : START_GAP;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [AW:0]   NPIX_W = (AW+1)'(NPIX);
    localparam logic [AW-1:0] LAST   = AW'(NPIX - 1);
    localparam logic [TW-1:0] GAP_END = TW'(START_GAP - 1);
    localparam logic [TW-1:0] TO_END  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, START, GAP, STREAM, WAIT_DONE, FINISH
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [NPIX];
    logic [AW-1:0]         idx;
    logic [TW-1:0]         timer;
    logic                  start_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] pix_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  terr_q;
    logic [AW:0]           cnt_q;
    logic                  wr_ok;

    assign bus.start          = start_q;
    assign bus.pixel_out      = pix_q;
    assign bus.pixel_in_valid = valid_q;
    assign bus.busy           = busy_q;
    assign bus.frame_done     = done_q;
    assign bus.timeout_err    = terr_q;
    assign bus.pixel_count    = cnt_q;

    // The buffer only changes while idle, so streaming reads are stable.
    assign wr_ok = bus.wr_en && (state == IDLE)
                && ({1'b0, bus.wr_addr} < NPIX_W);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            idx     <= '0;
            timer   <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            pix_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.go) begin
                        state   <= START;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        terr_q  <= 1'b0;
                        cnt_q   <= '0;
                        idx     <= '0;
                        timer   <= '0;
                    end
                end
                START: begin
                    timer <= '0;
                    if (START_GAP > 0) begin
                        state <= GAP;
                    end else begin
                        state   <= STREAM;
                        valid_q <= 1'b1;
                        pix_q   <= mem[idx];
                    end
                end
                GAP: begin
                    if (timer == GAP_END) begin
                        state   <= STREAM;
                        valid_q <= 1'b1;
                        pix_q   <= mem[idx];
                        timer   <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STREAM: begin
                    // valid is always high here, so ready alone marks a beat
                    if (bus.pixel_ready) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (idx == LAST) begin
                            valid_q <= 1'b0;
                            state   <= WAIT_DONE;
                            timer   <= '0;
                        end else begin
                            idx   <= idx + 1'b1;
                            pix_q <= mem[idx + 1'b1];
                        end
                    end
                end
                WAIT_DONE: begin
                    // done beats a timeout landing on the same edge
                    if (bus.cnn_done) begin
                        state  <= FINISH;
                        done_q <= 1'b1;
                    end else if (timer == TO_END) begin
                        state  <= IDLE;
                        terr_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                FINISH: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cnn_frame_feeder.sv
// Directed bench for cnn_frame_feeder: frame tables per cycle plus
// hand-written reset and gap sequences on two parameterisations.
module tb_cnn_frame_feeder;
    typedef struct {
        logic       go;
        logic       rdy;
        logic       done;
        logic       wen;
        logic       st;
        logic       vld;
        logic [7:0] pix;
        logic       fd;
        logic       bsy;
        logic       te;
        logic [4:0] cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       go = 1'b0;
    logic       pixel_ready = 1'b0;
    logic       cnn_done = 1'b0;

    int total = 0;
    int bad = 0;
    int beats = 0;
    vec_t tv[$];

    always #5 clk = ~clk;

    cnn_frame_feeder_if #(.AW(4), .DATA_WIDTH(8)) b1 ();
    cnn_frame_feeder_if #(.AW(4), .DATA_WIDTH(8)) b0 ();

    assign b1.wr_en = wr_en;
    assign b1.wr_addr = wr_addr;
    assign b1.wr_data = wr_data;
    assign b1.go = go;
    assign b1.pixel_ready = pixel_ready;
    assign b1.cnn_done = cnn_done;
    assign b0.wr_en = wr_en;
    assign b0.wr_addr = wr_addr;
    assign b0.wr_data = wr_data;
    assign b0.go = go;
    assign b0.pixel_ready = pixel_ready;
    assign b0.cnn_done = cnn_done;

    cnn_frame_feeder #(.START_GAP(1), .TIMEOUT(20)) dut (
        .clk(clk), .reset(reset), .bus(b1)
    );
    cnn_frame_feeder #(.START_GAP(0), .TIMEOUT(20)) dut0 (
        .clk(clk), .reset(reset), .bus(b0)
    );

    always @(posedge clk) begin
        if (b1.pixel_in_valid && pixel_ready) beats <= beats + 1;
    end

    function automatic vec_t sample(input bit use0);
        vec_t a = '{default: 0};
        if (use0) begin
            a.st = b0.start; a.vld = b0.pixel_in_valid;
            a.pix = b0.pixel_out; a.fd = b0.frame_done;
            a.bsy = b0.busy; a.te = b0.timeout_err;
            a.cnt = b0.pixel_count;
        end else begin
            a.st = b1.start; a.vld = b1.pixel_in_valid;
            a.pix = b1.pixel_out; a.fd = b1.frame_done;
            a.bsy = b1.busy; a.te = b1.timeout_err;
            a.cnt = b1.pixel_count;
        end
        return a;
    endfunction

    task automatic chk(input string nm, input int i, input vec_t e,
                       input vec_t a, input bit pix_always);
        bit ok;
        total++;
        ok = (a.st === e.st) && (a.vld === e.vld) && (a.fd === e.fd)
          && (a.bsy === e.bsy) && (a.te === e.te) && (a.cnt === e.cnt);
        if ((e.vld || pix_always) && (a.pix !== e.pix)) ok = 0;
        if (!ok) begin
            bad++;
            $display("FAIL %s[%0d] got st=%b v=%b px=%0d fd=%b busy=%b te=%b cnt=%0d want st=%b v=%b px=%0d fd=%b busy=%b te=%b cnt=%0d",
                     nm, i, a.st, a.vld, a.pix, a.fd, a.bsy, a.te, a.cnt,
                     e.st, e.vld, e.pix, e.fd, e.bsy, e.te, e.cnt);
        end
    endtask

    task automatic chk_zero(input string nm, input bit use0);
        vec_t z = '{default: 0};
        chk(nm, 0, z, sample(use0), 1'b1);
    endtask

    // Expected per-cycle outputs for one frame of pixels 16..31.
    function automatic void build(input int gap, input int stall_at,
                                  input int stall_len, input int waits,
                                  input bit to_mode, input int inj_at);
        vec_t v;
        int p = 0;
        int s = 0;
        tv.delete();
        v = '{default: 0}; v.go = 1; v.rdy = 1; v.st = 1; v.bsy = 1;
        tv.push_back(v);
        for (int g = 0; g < gap; g++) begin
            v = '{default: 0}; v.rdy = 1; v.bsy = 1;
            tv.push_back(v);
        end
        v = '{default: 0}; v.rdy = 1; v.bsy = 1; v.vld = 1; v.pix = 16;
        tv.push_back(v);
        while (p < 16) begin
            v = '{default: 0}; v.bsy = 1;
            if (p == stall_at && s < stall_len) begin
                v.rdy = 0; s++;
            end else begin
                v.rdy = 1; p++;
            end
            if (p == inj_at && v.rdy) begin
                v.go = 1; v.wen = 1;
            end
            if (p < 16) begin
                v.vld = 1; v.pix = 8'(16 + p); v.cnt = 5'(p);
            end else begin
                v.cnt = 16;
            end
            tv.push_back(v);
        end
        for (int w = 0; w < waits; w++) begin
            v = '{default: 0}; v.bsy = 1; v.cnt = 16;
            tv.push_back(v);
        end
        v = '{default: 0}; v.cnt = 16;
        if (to_mode) begin
            v.te = 1;
            tv.push_back(v);
            tv.push_back(v);
        end else begin
            v.done = 1; v.fd = 1; v.bsy = 1;
            tv.push_back(v);
            v = '{default: 0}; v.cnt = 16;
            tv.push_back(v);
        end
    endfunction

    task automatic run_table(input string nm, input bit use0);
        foreach (tv[i]) begin
            go = tv[i].go;
            pixel_ready = tv[i].rdy;
            cnn_done = tv[i].done;
            wr_en = tv[i].wen;
            wr_addr = 4'd0;
            wr_data = 8'hFF;
            @(posedge clk);
            @(negedge clk);
            chk(nm, i, tv[i], sample(use0), 1'b0);
        end
        go = 0; pixel_ready = 0; cnn_done = 0; wr_en = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int b_start;
        bit found;
        #12;
        chk_zero("reset", 0);
        chk_zero("reset0", 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            wr_en = 1; wr_addr = 4'(i); wr_data = 8'(i + 16);
            @(negedge clk);
        end
        wr_en = 0;
        @(negedge clk);

        build(1, -1, 0, 4, 0, -1);
        run_table("basic", 0);

        build(1, 3, 2, 4, 0, -1);
        b_start = beats;
        run_table("bp", 0);
        total++;
        if (beats - b_start != 16) begin
            bad++;
            $display("FAIL bp_beats got %0d want 16", beats - b_start);
        end

        build(1, -1, 0, 19, 1, -1);
        run_table("timeout", 0);

        build(1, -1, 0, 4, 0, 5);
        run_table("busy", 0);
        build(1, -1, 0, 4, 0, -1);
        run_table("after_busy", 0);

        go = 1; pixel_ready = 1;
        @(posedge clk);
        @(negedge clk);
        go = 0;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            if (b1.pixel_count == 5'd8) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL mid_wait got count=%0d want 8", b1.pixel_count);
        end
        #2 reset = 1'b0;
        #1;
        chk_zero("rst_mid", 0);
        chk_zero("rst_mid0", 1);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("post_rst", 0);
        pixel_ready = 0;

        build(1, -1, 0, 4, 0, -1);
        run_table("replay", 0);

        build(0, -1, 0, 19, 0, -1);
        run_table("gap0", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
